// File: rtl/processor_exec_pkg.sv
// Shared definitions for the execute/writeback stage: opcodes, ALU operation
// codes, IF condition codes and the stage state encoding.
package processor_exec_pkg;

  localparam logic [3:0] OP_NOP           = 4'd0;
  localparam logic [3:0] OP_ALU           = 4'd1;
  localparam logic [3:0] OP_MUL_SHIFT     = 4'd2;
  localparam logic [3:0] OP_ADD_IMM8      = 4'd3;
  localparam logic [3:0] OP_MOV_IMM11     = 4'd4;
  localparam logic [3:0] OP_MOV_IMM11_TOP = 4'd5;
  localparam logic [3:0] OP_LOAD          = 4'd6;
  localparam logic [3:0] OP_STORE         = 4'd7;
  localparam logic [3:0] OP_IF            = 4'd8;
  localparam logic [3:0] OP_CALL          = 4'd9;
  localparam logic [3:0] OP_RETURN        = 4'd10;
  localparam logic [3:0] OP_WAIT          = 4'd11;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_NOT  = 4'd5;
  localparam logic [3:0] ALU_OP_SHL  = 4'd6;
  localparam logic [3:0] ALU_OP_SHR  = 4'd7;
  localparam logic [3:0] ALU_OP_SAR  = 4'd8;
  localparam logic [3:0] ALU_OP_MOV  = 4'd9;
  localparam logic [3:0] ALU_OP_SLT  = 4'd10;
  localparam logic [3:0] ALU_OP_SLTU = 4'd11;

  typedef enum logic [2:0] {
    COND_EQZ    = 3'd0,
    COND_NEZ    = 3'd1,
    COND_LTZ    = 3'd2,
    COND_GEZ    = 3'd3,
    COND_GTZ    = 3'd4,
    COND_LEZ    = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } if_cond_e;

  typedef enum logic [1:0] {
    EXEC_IDLE = 2'd0,
    EXEC_MUL  = 2'd1,
    EXEC_WAIT = 2'd2
  } exec_state_e;

  function automatic if_cond_e cond_of(input logic [2:0] field);
    return if_cond_e'(field);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shift amounts come from b[4:0].
module alu
  import processor_exec_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] result
);

  logic [4:0] sh_s;
  assign sh_s = b[4:0];

  // Operation select
  always_comb begin
    result = '0;
    case (op)
      ALU_OP_ADD:  result = a + b;
      ALU_OP_SUB:  result = a - b;
      ALU_OP_AND:  result = a & b;
      ALU_OP_OR:   result = a | b;
      ALU_OP_XOR:  result = a ^ b;
      ALU_OP_NOT:  result = ~a;
      ALU_OP_SHL:  result = a << sh_s;
      ALU_OP_SHR:  result = a >> sh_s;
      ALU_OP_SAR:  result = $signed(a) >>> sh_s;
      ALU_OP_MOV:  result = b;
      ALU_OP_SLT:  result = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_OP_SLTU: result = {{(WORD_SIZE-1){1'b0}}, (a < b)};
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/exec_branch_unit.sv
// Branch decision and target for IF, CALL and RETURN (combinational).
module exec_branch_unit
  import processor_exec_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic [3:0]           opcode,
  input  logic [13:0]          code_word,
  input  logic [WORD_SIZE-1:0] rx,
  input  logic [ADDR_SIZE-1:0] ip,
  input  logic [WORD_SIZE-1:0] memory_out,
  output logic                 taken,
  output logic [ADDR_SIZE-1:0] target
);

  logic                 rx_neg_s;
  logic                 rx_zero_s;
  logic                 cond_s;
  logic [ADDR_SIZE-1:0] rel_s;

  assign rx_neg_s  = rx[WORD_SIZE-1];
  assign rx_zero_s = (rx == '0);
  assign rel_s     = {{(ADDR_SIZE-8){code_word[7]}}, code_word[7:0]};

  // IF condition evaluation on rx
  always_comb begin
    cond_s = 1'b0;
    case (cond_of(code_word[10:8]))
      COND_EQZ:    cond_s = rx_zero_s;
      COND_NEZ:    cond_s = !rx_zero_s;
      COND_LTZ:    cond_s = rx_neg_s;
      COND_GEZ:    cond_s = !rx_neg_s;
      COND_GTZ:    cond_s = !rx_neg_s && !rx_zero_s;
      COND_LEZ:    cond_s = rx_neg_s || rx_zero_s;
      COND_ALWAYS: cond_s = 1'b1;
      COND_NEVER:  cond_s = 1'b0;
      default:     cond_s = 1'b0;
    endcase
  end

  // Redirect decision and target per control-flow opcode
  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (opcode)
      OP_IF: begin
        taken  = cond_s;
        target = ip + rel_s;
      end
      OP_CALL: begin
        taken  = 1'b1;
        target = ADDR_SIZE'(code_word);
      end
      OP_RETURN: begin
        taken  = 1'b1;
        target = memory_out[ADDR_SIZE-1:0];
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

endmodule

// File: rtl/mulxx.sv
// Signed multiply followed by an arithmetic right shift, truncated to one word.
module mulxx #(
  parameter int WORD_SIZE = 18
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [4:0]           shift,
  output logic [WORD_SIZE-1:0] result
);

  localparam int PW = 2 * WORD_SIZE;

  logic signed [PW-1:0] a_ext_s;
  logic signed [PW-1:0] b_ext_s;
  logic signed [PW-1:0] prod_s;

  assign a_ext_s = {{WORD_SIZE{a[WORD_SIZE-1]}}, a};
  assign b_ext_s = {{WORD_SIZE{b[WORD_SIZE-1]}}, b};
  assign prod_s  = a_ext_s * b_ext_s;
  assign result  = WORD_SIZE'(prod_s >>> shift);

endmodule

// File: rtl/processor_exec_stage.sv
// Execute/writeback stage of the 18-bit core with multi-cycle MUL and WAIT stalls.
// Optional retired-instruction counter enabled by defining PROCESSOR_EXEC_PERF_EN.
module processor_exec_stage
  import processor_exec_pkg::*;
#(
  parameter int ADDR_SIZE   = 18,
  parameter int WORD_SIZE   = 18,
  parameter int MUL_LATENCY = 2,
  parameter int LINK_REG    = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] alu_data0,
  input  logic [WORD_SIZE-1:0] alu_data1,
  input  logic [WORD_SIZE-1:0] data1_plus_imm8,
  input  logic [WORD_SIZE-1:0] code_word,
  input  logic [ADDR_SIZE-1:0] ip,
  input  logic [ADDR_SIZE-1:0] ip_plus_one,
  input  logic [WORD_SIZE-1:0] memory_out,
  output logic                 reg_write_enable,
  output logic [2:0]           reg_write_addr,
  output logic [WORD_SIZE-1:0] reg_write_data,
  output logic                 mem_write_enable,
  output logic [ADDR_SIZE-1:0] mem_write_addr,
  output logic [WORD_SIZE-1:0] mem_write_data,
  output logic                 jump_valid,
  output logic [ADDR_SIZE-1:0] jump_addr,
  output logic                 busy,
  output logic [31:0]          perf_retired
);

  localparam int CNT_W = 11;

  exec_state_e          state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
  logic [WORD_SIZE-1:0] mul_a_r, mul_a_nx_s;
  logic [WORD_SIZE-1:0] mul_b_r, mul_b_nx_s;
  logic [4:0]           mul_sh_r, mul_sh_nx_s;
  logic [2:0]           mul_dest_r, mul_dest_nx_s;

  logic                 wb_en_nx_s;
  logic [2:0]           wb_addr_nx_s;
  logic [WORD_SIZE-1:0] wb_data_nx_s;
  logic                 st_en_nx_s;
  logic [ADDR_SIZE-1:0] st_addr_nx_s;
  logic [WORD_SIZE-1:0] st_data_nx_s;
  logic                 jv_nx_s;
  logic [ADDR_SIZE-1:0] ja_nx_s;

  logic [3:0]           opcode_s;
  logic [2:0]           rx_idx_s;
  logic [CNT_W-1:0]     wait_n_s;
  logic                 accept_s;
  logic                 mul_done_s;
  logic                 wait_done_s;
  logic [WORD_SIZE-1:0] alu_result_s;
  logic [WORD_SIZE-1:0] mul_result_s;
  logic [WORD_SIZE-1:0] mul_a_s;
  logic [WORD_SIZE-1:0] mul_b_s;
  logic [4:0]           mul_sh_s;
  logic                 br_taken_s;
  logic [ADDR_SIZE-1:0] br_target_s;

  assign opcode_s    = code_word[17:14];
  assign rx_idx_s    = code_word[13:11];
  assign wait_n_s    = code_word[10:0];
  assign in_ready    = !reset && (state_r == EXEC_IDLE);
  assign accept_s    = in_valid && in_ready;
  assign mul_done_s  = (cnt_r == CNT_W'(MUL_LATENCY - 1));
  assign wait_done_s = (cnt_r == 11'd1);

  // A stalled multiply computes from its latched operands, not from stage 2
  assign mul_a_s  = (state_r == EXEC_MUL) ? mul_a_r  : alu_data0;
  assign mul_b_s  = (state_r == EXEC_MUL) ? mul_b_r  : alu_data1;
  assign mul_sh_s = (state_r == EXEC_MUL) ? mul_sh_r : code_word[4:0];

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .op     (code_word[3:0]),
    .a      (alu_data0),
    .b      (alu_data1),
    .result (alu_result_s)
  );

  mulxx #(.WORD_SIZE(WORD_SIZE)) u_mulxx (
    .a      (mul_a_s),
    .b      (mul_b_s),
    .shift  (mul_sh_s),
    .result (mul_result_s)
  );

  exec_branch_unit #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) u_branch (
    .opcode     (opcode_s),
    .code_word  (code_word[13:0]),
    .rx         (alu_data0),
    .ip         (ip),
    .memory_out (memory_out),
    .taken      (br_taken_s),
    .target     (br_target_s)
  );

  // Next state, stall counter and next registered results
  always_comb begin
    state_nx_s    = state_r;
    cnt_nx_s      = cnt_r;
    mul_a_nx_s    = mul_a_r;
    mul_b_nx_s    = mul_b_r;
    mul_sh_nx_s   = mul_sh_r;
    mul_dest_nx_s = mul_dest_r;
    wb_en_nx_s    = 1'b0;
    wb_addr_nx_s  = 3'd0;
    wb_data_nx_s  = '0;
    st_en_nx_s    = 1'b0;
    st_addr_nx_s  = '0;
    st_data_nx_s  = '0;
    jv_nx_s       = 1'b0;
    ja_nx_s       = '0;
    case (state_r)
      EXEC_IDLE: begin
        if (accept_s) begin
          case (opcode_s)
            OP_ALU: begin
              wb_en_nx_s   = 1'b1;
              wb_addr_nx_s = rx_idx_s;
              wb_data_nx_s = alu_result_s;
            end
            OP_MUL_SHIFT: begin
              if (MUL_LATENCY > 1) begin
                mul_a_nx_s    = alu_data0;
                mul_b_nx_s    = alu_data1;
                mul_sh_nx_s   = code_word[4:0];
                mul_dest_nx_s = rx_idx_s;
                cnt_nx_s      = 11'd1;
                state_nx_s    = EXEC_MUL;
              end else begin
                wb_en_nx_s   = 1'b1;
                wb_addr_nx_s = rx_idx_s;
                wb_data_nx_s = mul_result_s;
              end
            end
            OP_ADD_IMM8: begin
              wb_en_nx_s   = 1'b1;
              wb_addr_nx_s = rx_idx_s;
              wb_data_nx_s = data1_plus_imm8;
            end
            OP_MOV_IMM11: begin
              wb_en_nx_s   = 1'b1;
              wb_addr_nx_s = rx_idx_s;
              wb_data_nx_s = {{(WORD_SIZE-11){code_word[10]}}, code_word[10:0]};
            end
            OP_MOV_IMM11_TOP: begin
              wb_en_nx_s   = 1'b1;
              wb_addr_nx_s = rx_idx_s;
              wb_data_nx_s = {code_word[10:0], {(WORD_SIZE-11){1'b0}}};
            end
            OP_LOAD: begin
              wb_en_nx_s   = 1'b1;
              wb_addr_nx_s = rx_idx_s;
              wb_data_nx_s = memory_out;
            end
            OP_STORE: begin
              st_en_nx_s   = 1'b1;
              st_addr_nx_s = data1_plus_imm8[ADDR_SIZE-1:0];
              st_data_nx_s = alu_data0;
            end
            OP_IF, OP_RETURN: begin
              jv_nx_s = br_taken_s;
              ja_nx_s = br_target_s;
            end
            OP_CALL: begin
              jv_nx_s      = br_taken_s;
              ja_nx_s      = br_target_s;
              wb_en_nx_s   = 1'b1;
              wb_addr_nx_s = 3'(LINK_REG);
              wb_data_nx_s = WORD_SIZE'(ip_plus_one);
            end
            OP_WAIT: begin
              if (wait_n_s != 11'd0) begin
                cnt_nx_s   = wait_n_s;
                state_nx_s = EXEC_WAIT;
              end else begin
                state_nx_s = EXEC_IDLE;
              end
            end
            default: state_nx_s = EXEC_IDLE;
          endcase
        end else begin
          state_nx_s = EXEC_IDLE;
        end
      end
      EXEC_MUL: begin
        if (mul_done_s) begin
          wb_en_nx_s   = 1'b1;
          wb_addr_nx_s = mul_dest_r;
          wb_data_nx_s = mul_result_s;
          state_nx_s   = EXEC_IDLE;
        end else begin
          cnt_nx_s = cnt_r + 11'd1;
        end
      end
      EXEC_WAIT: begin
        if (wait_done_s) begin
          state_nx_s = EXEC_IDLE;
        end else begin
          cnt_nx_s = cnt_r - 11'd1;
        end
      end
      default: state_nx_s = EXEC_IDLE;
    endcase
  end

  // State, operand latches and registered results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= EXEC_IDLE;
      cnt_r            <= 11'd0;
      mul_a_r          <= '0;
      mul_b_r          <= '0;
      mul_sh_r         <= 5'd0;
      mul_dest_r       <= 3'd0;
      busy             <= 1'b0;
      reg_write_enable <= 1'b0;
      reg_write_addr   <= 3'd0;
      reg_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_write_addr   <= '0;
      mem_write_data   <= '0;
      jump_valid       <= 1'b0;
      jump_addr        <= '0;
    end else begin
      state_r          <= state_nx_s;
      cnt_r            <= cnt_nx_s;
      mul_a_r          <= mul_a_nx_s;
      mul_b_r          <= mul_b_nx_s;
      mul_sh_r         <= mul_sh_nx_s;
      mul_dest_r       <= mul_dest_nx_s;
      busy             <= (state_nx_s != EXEC_IDLE);
      reg_write_enable <= wb_en_nx_s;
      reg_write_addr   <= wb_addr_nx_s;
      reg_write_data   <= wb_data_nx_s;
      mem_write_enable <= st_en_nx_s;
      mem_write_addr   <= st_addr_nx_s;
      mem_write_data   <= st_data_nx_s;
      jump_valid       <= jv_nx_s;
      jump_addr        <= ja_nx_s;
    end
  end

`ifdef PROCESSOR_EXEC_PERF_EN
  logic        retire_s;
  logic [31:0] perf_r;

  // An instruction retires when it completes; stalled ones retire on exit
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      EXEC_IDLE: begin
        if (!accept_s) begin
          retire_s = 1'b0;
        end else if ((opcode_s == OP_MUL_SHIFT) && (MUL_LATENCY > 1)) begin
          retire_s = 1'b0;
        end else if ((opcode_s == OP_WAIT) && (wait_n_s != 11'd0)) begin
          retire_s = 1'b0;
        end else begin
          retire_s = 1'b1;
        end
      end
      EXEC_MUL:  retire_s = mul_done_s;
      EXEC_WAIT: retire_s = wait_done_s;
      default:   retire_s = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_r <= 32'd0;
    end else if (retire_s) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_retired = perf_r;
`else
  assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_processor_exec_stage.sv
// Scoreboard bench for processor_exec_stage: directed cases then random traffic
// checked against an arithmetic reference model.
module tb_processor_exec_stage;

  localparam int AS = 18;
  localparam int WS = 18;
  localparam int ML = 3;
  localparam int LR = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WS-1:0] alu_data0 = '0, alu_data1 = '0, data1_plus_imm8 = '0, code_word = '0, memory_out = '0;
  logic [AS-1:0] ip = '0, ip_plus_one = '0;
  logic          reg_write_enable, mem_write_enable, jump_valid, busy;
  logic [2:0]    reg_write_addr;
  logic [WS-1:0] reg_write_data, mem_write_data;
  logic [AS-1:0] mem_write_addr, jump_addr;
  logic [31:0]   perf_retired;

  processor_exec_stage #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .MUL_LATENCY(ML), .LINK_REG(LR)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_data0(alu_data0), .alu_data1(alu_data1), .data1_plus_imm8(data1_plus_imm8),
    .code_word(code_word), .ip(ip), .ip_plus_one(ip_plus_one), .memory_out(memory_out),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .busy(busy), .perf_retired(perf_retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       cyc;
    bit       wbe;
    bit [2:0] wba;
    bit [17:0] wbd;
    bit       me;
    bit [17:0] ma;
    bit [17:0] md;
    bit       jv;
    bit [17:0] ja;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_at = 0;
  int   retired = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sx(input bit [17:0] v);
    return v[17] ? int'(v) - 262144 : int'(v);
  endfunction

  function automatic bit [17:0] alu_ref(input bit [3:0] op, input bit [17:0] a, input bit [17:0] b);
    longint r;
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0:  r = longint'(a) + longint'(b);
      4'd1:  r = longint'(a) - longint'(b);
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = 262143 - longint'(a);
      4'd6:  r = longint'(a) << s;
      4'd7:  r = longint'(a) >> s;
      4'd8:  r = longint'(sx(a)) >>> s;
      4'd9:  r = b;
      4'd10: r = (sx(a) < sx(b)) ? 1 : 0;
      4'd11: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return r[17:0];
  endfunction

  function automatic bit [17:0] mul_ref(input bit [17:0] a, input bit [17:0] b, input bit [4:0] sh);
    longint p;
    p = longint'(sx(a)) * longint'(sx(b));
    p = p >>> int'(sh);
    return p[17:0];
  endfunction

  function automatic bit cond_ref(input bit [2:0] c, input bit [17:0] rx);
    int r;
    r = sx(rx);
    case (c)
      3'd0: return r == 0;
      3'd1: return r != 0;
      3'd2: return r < 0;
      3'd3: return r >= 0;
      3'd4: return r > 0;
      3'd5: return r <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [17:0] mk(input bit [3:0] op, input bit [2:0] rx, input bit [10:0] low);
    return {op, rx, low};
  endfunction

  task automatic check_ready();
    bit er;
    er = (cyc >= ready_at);
    chk("in_ready", in_ready, er);
    chk("busy", busy, !er);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    check_ready();
  endtask

  task automatic issue(input bit [17:0] cw, input bit [17:0] d0, input bit [17:0] d1,
                       input bit [17:0] dpi, input bit [17:0] ipv, input bit [17:0] mem);
    exp_t e;
    bit   has;
    int   guard;
    int   n;
    longint t;
    bit [17:0] ipp1;
    guard = 0;
    @(negedge clock);
    check_ready();
    while (!in_ready && guard < 40) begin
      in_valid  = 1'($urandom_range(0, 1));
      code_word = 18'($urandom);
      alu_data0 = 18'($urandom);
      @(negedge clock);
      check_ready();
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, guard);
      return;
    end
    ipp1 = ipv + 18'd1;
    in_valid = 1'b1; code_word = cw; alu_data0 = d0; alu_data1 = d1;
    data1_plus_imm8 = dpi; ip = ipv; ip_plus_one = ipp1; memory_out = mem;
    e = '{default: 0};
    e.cyc = cyc + 1;
    ready_at = cyc + 1;
    has = 1'b0;
    retired++;
    case (cw[17:14])
      4'd1: begin has = 1; e.wbe = 1; e.wba = cw[13:11]; e.wbd = alu_ref(cw[3:0], d0, d1); end
      4'd2: begin
        has = 1; e.wbe = 1; e.wba = cw[13:11]; e.wbd = mul_ref(d0, d1, cw[4:0]);
        e.cyc = cyc + ML; ready_at = cyc + ML;
      end
      4'd3: begin has = 1; e.wbe = 1; e.wba = cw[13:11]; e.wbd = dpi; end
      4'd4: begin
        has = 1; e.wbe = 1; e.wba = cw[13:11];
        t = cw[10] ? longint'(cw[10:0]) - 2048 : longint'(cw[10:0]);
        e.wbd = t[17:0];
      end
      4'd5: begin
        has = 1; e.wbe = 1; e.wba = cw[13:11];
        t = longint'(cw[10:0]) * 128;
        e.wbd = t[17:0];
      end
      4'd6: begin has = 1; e.wbe = 1; e.wba = cw[13:11]; e.wbd = mem; end
      4'd7: begin has = 1; e.me = 1; e.ma = dpi; e.md = d0; end
      4'd8: begin
        if (cond_ref(cw[10:8], d0)) begin
          has = 1; e.jv = 1;
          t = longint'(ipv) + (cw[7] ? longint'(cw[7:0]) - 256 : longint'(cw[7:0]));
          e.ja = t[17:0];
        end
      end
      4'd9:  begin has = 1; e.jv = 1; e.ja = {4'd0, cw[13:0]}; e.wbe = 1; e.wba = 3'(LR); e.wbd = ipp1; end
      4'd10: begin has = 1; e.jv = 1; e.ja = mem; end
      4'd11: begin n = int'(cw[10:0]); ready_at = cyc + 1 + n; end
      default: has = 0;
    endcase
    if (has) sb_q.push_back(e);
    @(posedge clock);
  endtask

  // Monitor: pops and compares whenever the stage presents a result
  always @(negedge clock) begin
    if (!reset) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_output: expected at cycle %0d, still absent at cycle %0d", sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
      if (reg_write_enable || mem_write_enable || jump_valid) begin
        if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: wbe=%0b me=%0b jv=%0b at cycle %0d, none required",
                   reg_write_enable, mem_write_enable, jump_valid, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("reg_write_enable", reg_write_enable, mon_e.wbe);
          chk("mem_write_enable", mem_write_enable, mon_e.me);
          chk("jump_valid", jump_valid, mon_e.jv);
          if (mon_e.wbe) begin
            chk("reg_write_addr", reg_write_addr, mon_e.wba);
            chk("reg_write_data", reg_write_data, mon_e.wbd);
          end
          if (mon_e.me) begin
            chk("mem_write_addr", mem_write_addr, mon_e.ma);
            chk("mem_write_data", mem_write_data, mon_e.md);
          end
          if (mon_e.jv) chk("jump_addr", jump_addr, mon_e.ja);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [17:0] cw, d0;
    repeat (3) @(negedge clock);
    chk("rst_reg_write_enable", reg_write_enable, 1'b0);
    chk("rst_reg_write_data", reg_write_data, 18'd0);
    chk("rst_mem_write_enable", mem_write_enable, 1'b0);
    chk("rst_jump_valid", jump_valid, 1'b0);
    chk("rst_jump_addr", jump_addr, 18'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_perf", perf_retired, 32'd0);
    reset = 1'b0;
    ready_at = cyc;
    idle();

    issue(mk(4'd3, 3'd3, 11'd0), 18'h00005, 18'h0, 18'h00123, 18'h00010, 18'h0);
    idle();
    idle();
    chk("add_strobe_clears", reg_write_enable, 1'b0);
    issue(mk(4'd5, 3'd1, 11'h7FF), 18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    issue(mk(4'd4, 3'd2, 11'h400), 18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    issue(mk(4'd2, 3'd4, 11'd1), 18'h3FFFE, 18'h00005, 18'h0, 18'h0, 18'h0);
    issue(mk(4'd8, 3'd2, {3'd1, 8'h05}), 18'h0, 18'h0, 18'h0, 18'h00002, 18'h0);
    issue(mk(4'd8, 3'd2, {3'd0, 8'hFC}), 18'h0, 18'h0, 18'h0, 18'h00002, 18'h0);
    issue({4'd9, 14'h0100}, 18'h0, 18'h0, 18'h0, 18'h00050, 18'h0);
    issue(mk(4'd7, 3'd0, 11'd0), 18'h2AAAA, 18'h0, 18'h01234, 18'h0, 18'h0);
    issue(mk(4'd6, 3'd5, 11'd0), 18'h0, 18'h0, 18'h0, 18'h0, 18'h15555);
    issue(mk(4'd10, 3'd0, 11'd0), 18'h0, 18'h0, 18'h0, 18'h0, 18'h3FFFF);
    issue(mk(4'd11, 3'd0, 11'd2), 18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    issue(mk(4'd11, 3'd0, 11'd0), 18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    issue(mk(4'd15, 3'd0, 11'd0), 18'h0, 18'h0, 18'h0, 18'h0, 18'h0);

    for (int i = 0; i < 400; i++) begin
      cw = 18'($urandom);
      if (cw[17:14] == 4'd11) cw[10:0] = 11'($urandom_range(0, 4));
      d0 = 18'($urandom);
      if (cw[17:14] == 4'd8 && $urandom_range(0, 2) == 0) d0 = 18'd0;
      issue(cw, d0, 18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    repeat (12) idle();
    chk("scoreboard_empty", sb_q.size(), 0);
`ifdef PROCESSOR_EXEC_PERF_EN
    chk("perf_retired", perf_retired, retired);
`else
    chk("perf_retired_tied", perf_retired, 32'd0);
`endif

    issue(mk(4'd11, 3'd0, 11'd4), 18'h0, 18'h0, 18'h0, 18'h0, 18'h0);
    idle();
    idle();
    #2 reset = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_reg_write_enable", reg_write_enable, 1'b0);
    chk("abort_mem_write_enable", mem_write_enable, 1'b0);
    chk("abort_jump_valid", jump_valid, 1'b0);
    chk("abort_mem_write_addr", mem_write_addr, 18'd0);
    @(negedge clock);
    reset = 1'b0;
    ready_at = cyc;
    retired = 0;
    idle();
    chk("abort_perf", perf_retired, 32'd0);
    issue(mk(4'd3, 3'd6, 11'd0), 18'h0, 18'h0, 18'h2F00D, 18'h0, 18'h0);
    repeat (6) idle();
    chk("final_scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/processor_exec_stage.md
Name: processor_exec_stage

Overview:
- Parametrised successor of the third (execute/writeback) pipeline stage of the 18-bit core.
- Executes one decoded instruction per accepted cycle: ALU, mul-shift, immediate moves, loads, stores, IF, CALL, RETURN and WAIT.
- Registers all results: register writeback, memory write strobe and IP redirect.
- Applies back-pressure to stage 2 for the multi-cycle multiply and for WAIT.

Parameters:
- ADDR_SIZE, 18, width of instruction addresses and data addresses.
- WORD_SIZE, 18, data word and code word width.
- MUL_LATENCY, 2, cycles the mul-shift occupies the stage (1..8; 1 means no stall).
- LINK_REG, 7, register index written with the return address by CALL.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  stage-2 instruction present (replaces no_operation).
- in_ready  out  1  stage can accept this cycle.
- alu_data0, alu_data1  in  WORD_SIZE  rx and ry operand values.
- data1_plus_imm8  in  WORD_SIZE  ry+sext(imm8), used as address and as the ADD_IMM8 result.
- code_word  in  WORD_SIZE  instruction.
- ip, ip_plus_one  in  ADDR_SIZE  address of the instruction, and that address plus one.
- memory_out  in  WORD_SIZE  synchronous read data for data1_plus_imm8, valid in the accept cycle.
- reg_write_enable  out  1  registered writeback strobe.
- reg_write_addr  out  3  destination register.
- reg_write_data  out  WORD_SIZE  writeback value.
- mem_write_enable  out  1  registered store strobe.
- mem_write_addr  out  ADDR_SIZE  store address.
- mem_write_data  out  WORD_SIZE  store data.
- jump_valid  out  1  one-cycle redirect pulse; stages 1-2 flush on it.
- jump_addr  out  ADDR_SIZE  redirect target.
- busy  out  1  MUL or WAIT in progress.
- perf_retired  out  32  retired instruction count (see Optional Feature).

Behaviour:
- Reset (asynchronous): all strobes 0, all data and address outputs 0, state IDLE, counters 0. in_ready is 0 while reset is asserted and 1 in IDLE after reset.
- Opcode field is code_word[17:14]; opcode constants OP_* come from the package. rx = code_word[13:11].
- Accept occurs when in_valid && in_ready. Outputs are registered, so every result appears exactly one cycle after accept, except MUL.
- Strobes are single-cycle pulses and are 0 in any cycle without a completing instruction.
- Writeback results by opcode:
  - ADD_IMM8: data1_plus_imm8.
  - MOV_IMM11: sign-extended code_word[10:0].
  - MOV_IMM11_TOP: {code_word[10:0], 7'b0}.
  - LOAD: memory_out.
  - ALU: ALU result with op = code_word[3:0].
- STORE: mem_write_enable=1, addr=data1_plus_imm8[ADDR_SIZE-1:0], data=alu_data0.
- IF:
  - Condition code_word[10:8]: 0 rx==0; 1 rx!=0; 2 rx<0 (signed); 3 rx>=0; 4 rx>0; 5 rx<=0; 6 always; 7 never.
  - When taken: jump_valid=1, jump_addr = ip + sext(code_word[7:0]), arithmetic modulo 2^ADDR_SIZE (wraps).
- CALL: jump_addr = zero-extended code_word[13:0], jump_valid=1, and in the same cycle writes ip_plus_one to LINK_REG.
- RETURN: jump_valid=1, jump_addr = memory_out[ADDR_SIZE-1:0].
- Unknown opcode: treated as NOP; still retired.
- State machine IDLE / MUL / WAIT:
  - MUL: on accept of MUL_SHIFT with MUL_LATENCY>1, operands and shift are latched, in_ready=0, and a counter counts to MUL_LATENCY-1. The writeback pulse appears MUL_LATENCY cycles after accept, then the stage returns to IDLE. With MUL_LATENCY=1 the stage stays in IDLE.
  - mul-shift result = (signed rx * signed ry) >> code_word[4:0] (arithmetic shift), truncated to WORD_SIZE.
  - WAIT: n = code_word[10:0]. n=0 completes like a NOP. Otherwise in_ready=0 for exactly n cycles after accept, then IDLE.
- busy is 1 exactly while state is not IDLE.
- in_valid during a stall is ignored. Stage 2 holds its inputs stable until in_ready is 1.
- Reset asserted mid-MUL or mid-WAIT aborts the operation; no writeback is issued.
- Only one redirect and one writeback per instruction. When a CALL redirects, the instruction accepted in the next cycle is stage 2's responsibility to kill; this stage executes whatever is presented with in_valid.

Optional Feature:
- PROCESSOR_EXEC_PERF_EN defined: perf_retired increments by 1 on every instruction completion (including NOPs and taken or untaken IF), wraps at 2^32, and is cleared by reset.
- Not defined: perf_retired is tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds the OP_* opcode constants, the ALU_OP_* codes, an IF-condition enum (COND_EQZ..COND_NEVER) and the exec state enum (EXEC_IDLE, EXEC_MUL, EXEC_WAIT).
- Reuse the existing alu and mulxx modules as instances.
- One new sub-module, exec_branch_unit: combinational condition evaluation plus target computation. Inputs are opcode, code_word, rx, ip and memory_out; outputs are taken and target.

Test Plan:
- Reset, then ADD_IMM8 with data1_plus_imm8=0x00123 and rx=3 -> next cycle reg_write_enable=1, addr=3, data=0x00123; the following cycle the strobe is 0.
- MOV_IMM11_TOP with imm11=0x7FF -> data=0x3FF80; MOV_IMM11 with imm11=0x400 -> data=0x3FC00.
- MUL_SHIFT with MUL_LATENCY=3, rx=-2, ry=5, shift=1 -> in_ready=0 for 2 cycles, then writeback data=0x3FFFB (-5) on cycle 3.
- IF cond=1 with rx=0 -> no jump; IF cond=0 with rx=0, ip=0x00002, imm8=0xFC -> jump_valid=1, jump_addr=0x3FFFE (wrap).
- CALL imm14=0x0100 at ip=0x00050 -> jump_addr=0x00100 and writes 0x00051 to r7 in the same cycle.
- WAIT n=4 with reset asserted after 2 cycles -> all outputs 0 immediately; in_ready=1 after reset release; perf_retired=0 when PROCESSOR_EXEC_PERF_EN is defined.
